// File: rtl/if_id_branch_decode.sv
// IF/ID pipeline register with jump / branch-on-zero decode and a HALT spin state.
// Drives the fetch redirect pair (pcsrc, PC2) and squashes the one wrong-path
// instruction that follows a taken redirect.
// Optional build macro IF_ID_BRANCH_STATS_EN adds the saturating taken_count output.
module if_id_branch_decode #(
  parameter int unsigned PC_W    = 8,
  parameter int unsigned INSTR_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PC_W-1:0]    pc_in,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               zero_flag,
  output logic               pcsrc,
  output logic [PC_W-1:0]    PC2,
  output logic               id_valid,
  output logic [PC_W-1:0]    id_pc,
  output logic [INSTR_W-1:0] id_instr,
  output logic               halted
`ifdef IF_ID_BRANCH_STATS_EN
  ,
  output logic [7:0]         taken_count
`endif
);

  localparam int unsigned OffW = 6;

  typedef enum logic [1:0] {StRun, StFlush, StHalt} state_e;

  state_e             state_q;
  logic               id_valid_q;
  logic [PC_W-1:0]    id_pc_q;
  logic [INSTR_W-1:0] id_instr_q;
  logic [PC_W-1:0]    halt_pc_q;

  logic [1:0]         opcode;
  logic [PC_W-1:0]    offset;
  logic [PC_W-1:0]    target;
  logic               off_zero;
  logic               is_jmp;
  logic               is_halt;
  logic               is_bz_taken;

  assign opcode      = id_instr_q[INSTR_W-1 -: 2];
  assign offset      = {{(PC_W-OffW){id_instr_q[OffW-1]}}, id_instr_q[OffW-1:0]};
  assign target      = id_pc_q + offset;
  assign off_zero    = (id_instr_q[OffW-1:0] == '0);
  assign is_jmp      = id_valid_q && (opcode == 2'b11) && !off_zero;
  assign is_halt     = id_valid_q && (opcode == 2'b11) && off_zero;
  assign is_bz_taken = id_valid_q && (opcode == 2'b10) && zero_flag;

  assign id_valid = id_valid_q;
  assign id_pc    = id_pc_q;
  assign id_instr = id_instr_q;
  assign halted   = (state_q == StHalt);

  // Redirect request to fetch, derived only from IF/ID contents, state and zero_flag.
  always_comb begin
    pcsrc = 1'b0;
    PC2   = '0;
    unique case (state_q)
      StRun: begin
        if (is_halt) begin
          pcsrc = 1'b1;
          PC2   = id_pc_q;
        end else if (is_jmp || is_bz_taken) begin
          pcsrc = 1'b1;
          PC2   = target;
        end
      end
      StFlush: ;
      StHalt: begin
        pcsrc = 1'b1;
        PC2   = halt_pc_q;
      end
      default: ;
    endcase
  end

  // Control FSM and IF/ID register; a taken redirect turns the next latch into a bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StRun;
      id_valid_q <= 1'b0;
      id_pc_q    <= '0;
      id_instr_q <= '0;
      halt_pc_q  <= '0;
    end else begin
      unique case (state_q)
        StRun: begin
          id_pc_q <= pc_in;
          if (pcsrc) begin
            id_valid_q <= 1'b0;
            id_instr_q <= '0;
            if (is_halt) begin
              halt_pc_q <= id_pc_q;
              state_q   <= StHalt;
            end else begin
              state_q <= StFlush;
            end
          end else begin
            id_valid_q <= 1'b1;
            id_instr_q <= instr_in;
          end
        end
        StFlush: begin
          // Fetch is now presenting the redirect target.
          id_valid_q <= 1'b1;
          id_pc_q    <= pc_in;
          id_instr_q <= instr_in;
          state_q    <= StRun;
        end
        StHalt: begin
          // Spin on bubbles; only reset leaves this state.
          id_valid_q <= 1'b0;
          id_pc_q    <= pc_in;
          id_instr_q <= '0;
        end
        default: state_q <= StRun;
      endcase
    end
  end

`ifdef IF_ID_BRANCH_STATS_EN
  logic [7:0] taken_count_q;

  assign taken_count = taken_count_q;

  // Saturating count of redirects issued from RUN (HALT entry included).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      taken_count_q <= '0;
    end else if ((state_q == StRun) && pcsrc && (taken_count_q != 8'hFF)) begin
      taken_count_q <= taken_count_q + 8'd1;
    end
  end
`endif

endmodule

// File: doc/if_id_branch_decode.md
Name: if_id_branch_decode

Overview:
- Consumer end of the instruction-fetch interface.
- Latches the fetched PC and instruction into an IF/ID pipeline register each cycle.
- Decodes jump and branch-on-zero instructions and drives the redirect pair pcsrc/PC2 back into the fetch stage.
- Squashes the single wrong-path instruction after a taken redirect, and implements a HALT spin state.

Parameters:
- PC_W, 8, program counter width; matches the fetch PC and instruction-memory address width.
- INSTR_W, 8, instruction width; the opcode is always the top 2 bits and the offset field is the low 6 bits.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- pc_in  input  PC_W  PC of the instruction currently presented by fetch.
- instr_in  input  INSTR_W  instruction at pc_in.
- zero_flag  input  1  zero result from execute, sampled combinationally during the decode cycle.
- pcsrc  output  1  redirect select to fetch; 1 = load PC2 on the next edge.
- PC2  output  PC_W  redirect target.
- id_valid  output  1  IF/ID holds a real instruction.
- id_pc  output  PC_W  registered PC.
- id_instr  output  INSTR_W  registered instruction; 0 (NOP) when it is a bubble.
- halted  output  1  block is in the HALT state.
- taken_count  output  8  taken-redirect counter; present only with the optional feature.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=RUN, id_valid=0, id_pc=0, id_instr=0, halted=0, pcsrc=0, PC2=0, taken_count=0.
  - Fetch resets its PC to 0 at the same time, so the first edge after release latches PC 0 with id_valid=1.
- Decode (id_instr[7:6], off = id_instr[5:0] sign-extended to PC_W):
  - 00, 01: non-branch; pass through, no redirect.
  - 11, off!=0: JMP; always taken.
  - 11, off==0: HALT.
  - 10: BZ; taken only when zero_flag=1. off==0 gives a branch-to-self.
- Target: target = id_pc + off, modulo 2^PC_W (wraps in both directions).
- pcsrc/PC2 are combinational from registered state, IF/ID contents and zero_flag only. They are never driven from pc_in or instr_in.
- State RUN:
  - id_valid=0, or non-branch, or BZ with zero_flag=0: pcsrc=0, PC2=0. Next edge latches pc_in/instr_in with id_valid=1 and the state stays RUN.
  - Taken JMP/BZ: pcsrc=1, PC2=target. Next edge loads a bubble (id_valid=0, id_instr=0, id_pc=pc_in) and the state goes to FLUSH.
  - HALT: pcsrc=1, PC2=id_pc. Next edge stores halt_pc=id_pc, loads a bubble, state goes to HALT and halted=1.
- State FLUSH:
  - IF/ID holds a bubble, so pcsrc=0.
  - Fetch is presenting the target instruction; the next edge latches it with id_valid=1 and the state returns to RUN.
  - Net cost of a taken redirect: exactly one bubble cycle.
- State HALT:
  - pcsrc=1, PC2=halt_pc every cycle; id_valid=0; halted=1. instr_in is ignored.
  - Only reset exits this state.
- Redirect latency: redirect is visible in the cycle after the branch is latched; fetch PC equals target one edge later.
- Boundary cases:
  - A branch in the shadow of a taken branch is always squashed and never decoded.
  - A BZ to self with zero_flag held at 1 loops with one bubble per iteration.
  - Reset asserted in any state, including mid-FLUSH or HALT, returns everything to reset values immediately.

Optional Feature:
- Macro: IF_ID_BRANCH_STATS_EN.
- Defined:
  - taken_count increments on every edge where state=RUN and pcsrc=1, including entry into HALT.
  - The counter saturates at 255 and does not increment while in HALT.
  - It resets to 0.
- Undefined: the taken_count port and its counter are absent; all other behaviour is identical.

Test Plan:
- Reset release with fetch presenting pc_in=0, instr_in=0x05 -> after the 1st edge: id_valid=1, id_pc=0, id_instr=0x05, pcsrc=0.
- JMP 0xC4 (+4) latched at id_pc=0x10 -> pcsrc=1, PC2=0x14 for one cycle.
  - Next edge: id_valid=0, id_instr=0, state FLUSH.
  - Following edge: id_pc=0x14, id_valid=1.
- BZ 0xBF (-1) at id_pc=0x00:
  - zero_flag=0 -> pcsrc=0.
  - zero_flag=1 -> pcsrc=1, PC2=0xFF (wrap).
- HALT 0xC0 at id_pc=0x22 -> pcsrc=1, PC2=0x22.
  - From the next edge: halted=1, pcsrc=1, PC2=0x22 held for 20+ cycles regardless of instr_in.
- Back-to-back JMP at 0x30 and JMP at 0x31 -> only the 0x30 target is taken; the 0x31 instruction is never valid in IF/ID.
- Reset pulsed during FLUSH and during HALT -> all outputs return to 0 asynchronously before the next edge.
- With IF_ID_BRANCH_STATS_EN defined: 300 taken JMPs -> taken_count=255.
